gate_trigger_controller: RTL and testbench

//  Upstream of the ADSR envelope_generator: converts a stream of note-on/note-off events

---
 rtl/gate_trigger_controller.sv | 160 ++++++++++++++++
 tb/tb_gate_trigger_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_trigger_controller.sv
// Turns note-on/note-off events into the envelope gate: held-note count, minimum gate length,
// forced low gap on re-trigger. Optional statistics counters under `GATE_CTRL_STATS_EN.
module gate_trigger_controller #(
  parameter int unsigned RETRIG_GAP_TICKS = 2,
  parameter int unsigned MIN_GATE_TICKS   = 88,
  parameter int unsigned MAX_NOTES        = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic                             ev_note_on,
  input  logic                             legato,
  output logic                             gate,
  output logic [$clog2(MAX_NOTES+1)-1:0]   held_count
`ifdef GATE_CTRL_STATS_EN
  ,
  output logic [15:0]                      retrig_count,
  output logic [15:0]                      dropped_count
`endif
);

  localparam int unsigned HeldW = $clog2(MAX_NOTES + 1);
  localparam int unsigned GapW  = $clog2(RETRIG_GAP_TICKS + 1);
  // A zero minimum still needs a 1-bit counter that simply never moves.
  localparam int unsigned MinW  = (MIN_GATE_TICKS == 0) ? 1 : $clog2(MIN_GATE_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StOn, StPendOff, StGap} state_e;

  state_e            state_q, state_d;
  logic [HeldW-1:0]  held_q, held_d;
  logic [MinW-1:0]   min_q, min_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              gate_q, gate_d;
  logic              ev_fire, is_on, is_off, held_at_max, held_le_one, min_done, pend_expire;
  logic              enter_gap, drop_ev;
  logic [MinW:0]     min_inc;

  assign ev_ready    = (state_q != StGap) && !rst;
  assign ev_fire     = ev_valid && ev_ready;
  assign is_on       = ev_fire && ev_note_on;
  assign is_off      = ev_fire && !ev_note_on;
  assign held_at_max = (held_q == HeldW'(MAX_NOTES));
  assign held_le_one = (held_q <= HeldW'(1));
  assign min_done    = (min_q == MinW'(MIN_GATE_TICKS));
  assign min_inc     = {1'b0, min_q} + (MinW + 1)'(1);
  assign pend_expire = sample_tick && (min_inc >= (MinW + 1)'(MIN_GATE_TICKS));

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    min_d     = min_q;
    gap_d     = gap_q;
    enter_gap = 1'b0;
    drop_ev   = 1'b0;

    if (is_on) begin
      if (held_at_max) drop_ev = 1'b1;
      else             held_d  = held_q + HeldW'(1);
    end else if (is_off) begin
      if (held_q == '0) drop_ev = 1'b1;
      else              held_d  = held_q - HeldW'(1);
    end

    // Tick advances the counters of the current state; transitions below may override.
    if (sample_tick) begin
      if ((state_q == StOn || state_q == StPendOff) && !min_done) min_d = min_q + MinW'(1);
      if (state_q == StGap && gap_q != GapW'(RETRIG_GAP_TICKS))  gap_d = gap_q + GapW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (is_on) begin
          state_d = StOn;
          min_d   = '0;
        end
      end
      StOn: begin
        if (is_on && !legato) begin
          state_d   = StGap;
          gap_d     = '0;
          enter_gap = 1'b1;
        end else if (is_off && held_le_one) begin
          state_d = min_done ? StIdle : StPendOff;
        end
      end
      StPendOff: begin
        if (is_on) begin
          if (legato) begin
            state_d = StOn;
          end else begin
            state_d   = StGap;
            gap_d     = '0;
            enter_gap = 1'b1;
          end
        end else if (pend_expire) begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (sample_tick && gap_q == GapW'(RETRIG_GAP_TICKS - 1)) begin
          state_d = StOn;
          min_d   = '0;
          gap_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    gate_d = (state_d == StOn) || (state_d == StPendOff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      held_q  <= '0;
      min_q   <= '0;
      gap_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      min_q   <= min_d;
      gap_q   <= gap_d;
      gate_q  <= gate_d;
    end
  end

  assign gate       = gate_q;
  assign held_count = held_q;

`ifdef GATE_CTRL_STATS_EN
  logic [15:0] retrig_q, retrig_d, dropped_q, dropped_d;

  always_comb begin
    retrig_d  = retrig_q;
    dropped_d = dropped_q;
    if (enter_gap && retrig_q != 16'hFFFF) retrig_d  = retrig_q + 16'd1;
    if (drop_ev && dropped_q != 16'hFFFF)  dropped_d = dropped_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retrig_q  <= '0;
      dropped_q <= '0;
    end else begin
      retrig_q  <= retrig_d;
      dropped_q <= dropped_d;
    end
  end

  assign retrig_count  = retrig_q;
  assign dropped_count = dropped_q;
`else
  logic unused_stats;
  assign unused_stats = enter_gap ^ drop_ev;
`endif

endmodule

// File: tb/tb_gate_trigger_controller.sv
// Scoreboard bench for gate_trigger_controller: a cycle model queues expected outputs, a monitor
// compares them after each edge; directed checks cover the timing claims of each scenario.
module tb_gate_trigger_controller;

  localparam int RG = 2;
  localparam int MG = 88;
  localparam int MN = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_note_on = 1'b0;
  logic       legato = 1'b0;
  logic       ev_ready;
  logic       gate;
  logic [3:0] held_count;
`ifdef GATE_CTRL_STATS_EN
  logic [15:0] retrig_count, dropped_count;
`endif

  gate_trigger_controller #(
    .RETRIG_GAP_TICKS(RG),
    .MIN_GATE_TICKS  (MG),
    .MAX_NOTES       (MN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .legato       (legato),
    .gate         (gate),
    .held_count   (held_count)
`ifdef GATE_CTRL_STATS_EN
    ,
    .retrig_count (retrig_count),
    .dropped_count(dropped_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int gate;
    int held;
    int rtr;
    int drp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Model: 0 idle, 1 on, 2 pend_off, 3 gap
  int m_state = 0, m_held = 0, m_min = 0, m_gap = 0, m_rtr = 0, m_drp = 0, m_gate = 0;
  int phase = 0;
  bit last_acc;
  int dut_ready_s;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit t, input bit v, input bit on, input bit leg);
    int   ns, nh, nmin, ngap;
    bit   rdy, fire;
    exp_t e;
    @(negedge clk);
    rst = r; sample_tick = t; ev_valid = v; ev_note_on = on; legato = leg;
    #1;
    rdy = !r && (m_state != 3);
    dut_ready_s = int'(ev_ready);
    check("ev_ready", dut_ready_s, int'(rdy));
    fire = v && rdy;
    last_acc = fire;
    if (r) begin
      m_state = 0; m_held = 0; m_min = 0; m_gap = 0; m_rtr = 0; m_drp = 0;
    end else begin
      ns = m_state; nh = m_held; nmin = m_min; ngap = m_gap;
      if (fire && on) begin
        if (m_held < MN) nh = m_held + 1; else m_drp++;
      end else if (fire && !on) begin
        if (m_held > 0) nh = m_held - 1; else m_drp++;
      end
      if (t && (m_state == 1 || m_state == 2) && m_min < MG) nmin = m_min + 1;
      if (t && m_state == 3 && m_gap < RG) ngap = m_gap + 1;
      case (m_state)
        0: if (fire && on) begin ns = 1; nmin = 0; end
        1: begin
          if (fire && on && !leg) begin ns = 3; ngap = 0; m_rtr++; end
          else if (fire && !on && nh == 0) ns = (m_min == MG) ? 0 : 2;
        end
        2: begin
          if (fire && on) begin
            if (leg) ns = 1;
            else begin ns = 3; ngap = 0; m_rtr++; end
          end else if (t && m_min + 1 >= MG) ns = 0;
        end
        default: if (t && m_gap == RG - 1) begin ns = 1; nmin = 0; ngap = 0; end
      endcase
      m_state = ns; m_held = nh; m_min = nmin; m_gap = ngap;
    end
    m_gate = (m_state == 1 || m_state == 2) ? 1 : 0;
    e.gate = m_gate; e.held = m_held; e.rtr = m_rtr; e.drp = m_drp;
    sb_q.push_back(e);
    phase = (phase + 1) % 3;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_gate", int'(gate), mon_e.gate);
      check("sb_held", int'(held_count), mon_e.held);
`ifdef GATE_CTRL_STATS_EN
      check("sb_retrig", int'(retrig_count), mon_e.rtr);
      check("sb_dropped", int'(dropped_count), mon_e.drp);
`endif
    end
  end

  task automatic cyc(input bit v, input bit on, input bit leg);
    step(1'b0, phase == 2, v, on, leg);
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    bit t;
    while (k < n) begin
      t = (phase == 2);
      cyc(1'b0, 1'b0, 1'b0);
      if (t) k++;
    end
  endtask

  task automatic send(input bit on, input bit leg);
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cyc(1'b1, on, leg);
      done = last_acc;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, low;
    @(posedge clk);
    do_reset();
    check("reset_gate", int'(gate), 0);
    check("reset_held", int'(held_count), 0);

    // Reset mid-gate
    send(1'b1, 1'b0);
    run_ticks(5);
    check("t1_gate_before_rst", int'(gate), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t1_rst_ready", dut_ready_s, 0);
    check("t1_gate_after_rst", int'(gate), 0);
    check("t1_held_after_rst", int'(held_count), 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_ready_idle", int'(ev_ready), 1);

    // Long note
    send(1'b1, 1'b0);
    check("t2_gate_rise", int'(gate), 1);
    check("t2_held1", int'(held_count), 1);
    run_ticks(200);
    send(1'b0, 1'b0);
    check("t2_gate_fall", int'(gate), 0);
    check("t2_held0", int'(held_count), 0);

    // Short note stretched to the minimum gate
    send(1'b1, 1'b0);
    run_ticks(10);
    send(1'b0, 1'b0);
    check("t3_gate_held", int'(gate), 1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      run_ticks(1);
      cnt++;
      if (gate == 1'b0) break;
    end
    check("t3_extra_ticks", cnt, MG - 10);

    // Re-trigger with gap
    send(1'b1, 1'b0);
    run_ticks(50);
    send(1'b1, 1'b0);
    check("t4_gap_gate", int'(gate), 0);
    check("t4_gap_ready", int'(ev_ready), 0);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      run_ticks(1);
      low++;
      if (gate == 1'b1) break;
    end
    check("t4_gap_ticks", low, RG);
    check("t4_held2", int'(held_count), 2);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    run_ticks(100);
    check("t4_idle", int'(gate), 0);

    // Same with legato: no low pulse
    send(1'b1, 1'b1);
    run_ticks(50);
    send(1'b1, 1'b1);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      run_ticks(1);
      if (gate == 1'b0) low++;
    end
    check("t4_legato_low", low, 0);
    check("t4_legato_held", int'(held_count), 2);
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    run_ticks(100);

    // Saturation
    do_reset();
    for (int i = 0; i < 9; i++) send(1'b1, 1'b1);
    check("t5_held_sat", int'(held_count), MN);
    run_ticks(100);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 1'b0);
      if (i == 6) check("t5_gate_7th", int'(gate), 1);
    end
    check("t5_gate_8th", int'(gate), 0);
    send(1'b0, 1'b0);
    check("t5_held_9th", int'(held_count), 0);
`ifdef GATE_CTRL_STATS_EN
    check("t5_dropped", int'(dropped_count), 2);
`endif

    // Event colliding with the gap-exit tick
    send(1'b1, 1'b0);
    run_ticks(3);
    send(1'b1, 1'b0);
    run_ticks(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_stalled", dut_ready_s, 0);
    check("t6_gate_on", int'(gate), 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_accepted", dut_ready_s, 1);
    check("t6_held", int'(held_count), 3);
    check("t6_regap", int'(gate), 0);
    run_ticks(4);

    @(posedge clk);
    #3;
    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
